// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the dds_nco_core NCO.
// Holds the waveform-select enum, the FTW load FSM state type and the
// constants/step function of the optional phase-dither LFSR.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_TRI  = 2'd1,
    MODE_SAW  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } load_st_e;

  // Fibonacci LFSR x^15 + x^14 + 1: feedback taps are bits 14 and 13.
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dds_quarter_sine_lut.sv
// dds_quarter_sine_lut: combinational quarter-wave sine magnitude table.
// Entry k holds round(A*sin(pi/2*k/N)), N = 2^(PHASE_W-2), A = 2^(OUT_W-1)-1.
// The table contents are fixed at elaboration from the parameters.
module dds_quarter_sine_lut
  import dds_pkg::*;
#(
  parameter int PHASE_W = 14,
  parameter int OUT_W   = 12
) (
  input  logic [PHASE_W-3:0] idx,
  output logic [OUT_W-2:0]   mag
);

  localparam int  N   = 2 ** (PHASE_W - 2);
  localparam real A   = real'((2 ** (OUT_W - 1)) - 1);
  localparam real PI  = 3.14159265358979;

  logic [OUT_W-2:0] rom [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam real ANG = PI / 2.0 * real'(k) / real'(N);
    assign rom[k] = (OUT_W-1)'($rtoi(A * $sin(ANG) + 0.5));
  end

  assign mag = rom[idx];

endmodule

// File: rtl/dds_nco_core.sv
// dds_nco_core: phase-accumulator NCO with byte-serial FTW load, commit of a
// new FTW only at a phase wrap (or at once while idle), phase offset, four
// waveforms and a 2-stage registered output pipeline.
// Optional build macro: DDS_PHASE_DITHER_EN adds LFSR phase dither before
// truncation; without it the phase is plainly truncated.
module dds_nco_core
  import dds_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int PHASE_W = 14,
  parameter int OUT_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               ftw_valid,
  input  logic [7:0]         ftw_byte,
  input  logic               ftw_last,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               sync_out,
  output logic               ftw_pending
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0]   acc_q, acc_d, ftw_q, ftw_d, stage_q, stage_d;
  logic [ACC_W:0]     sum;
  logic               carry, wrap_q, wrap_d;
  load_st_e           st_q, st_d;
  logic               pend_q, pend_d;
  logic [PHASE_W-1:0] acc_top;
  logic [PHASE_W-1:0] p1_q, p1_d;
  mode_e              mode1_q, mode1_d;
  logic               wrap1_q, wrap1_d, ena1_q, ena1_d;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               sync_q, sync_d, valid_q, valid_d;
  logic [1:0]         quad;
  logic [PHASE_W-3:0] lut_idx;
  logic [OUT_W-2:0]   lut_mag;
  logic [PHASE_W-2:0] tri_val;

  // Accumulator advance; wrap is the carry out of an enabled add.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, ftw_q};
    carry = ena & sum[ACC_W];
    if (ena) begin
      acc_d = sum[ACC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
    wrap_d = carry;
  end

  // FTW load FSM: shift bytes into the stage, commit at wrap or while ena=0.
  // A new byte always wins over a coinciding commit.
  always_comb begin
    st_d    = st_q;
    stage_d = stage_q;
    ftw_d   = ftw_q;
    if (ftw_valid) begin
      stage_d = {stage_q[ACC_W-9:0], ftw_byte};
      if (ftw_last) begin
        st_d = ST_PEND;
      end else begin
        st_d = ST_LOAD;
      end
    end else begin
      case (st_q)
        ST_IDLE: st_d = ST_IDLE;
        ST_LOAD: st_d = ST_LOAD;
        ST_PEND: begin
          if (!ena || carry) begin
            ftw_d = stage_q;
            st_d  = ST_IDLE;
          end else begin
            st_d = ST_PEND;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
    pend_d = (st_d == ST_PEND);
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam logic [ACC_W-1:0] DITH_MASK =
    (ACC_W'(1'b1) << (ACC_W - PHASE_W)) - ACC_W'(1'b1);
  logic [14:0]      lfsr_q, lfsr_d;
  logic [ACC_W-1:0] dith_acc;

  // Dither source steps once per enabled cycle; truncated phase keeps the carry.
  always_comb begin
    if (ena) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
    dith_acc = acc_q + (ACC_W'(lfsr_q) & DITH_MASK);
    acc_top  = dith_acc[ACC_W-1 -: PHASE_W];
  end

  // Dither LFSR register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Plain truncation of the accumulator to the phase width.
  always_comb begin
    acc_top = acc_q[ACC_W-1 -: PHASE_W];
  end
`endif

  // Stage 1 inputs: offset phase plus the control bits travelling with it.
  always_comb begin
    p1_d    = acc_top + phase_off;
    mode1_d = mode_e'(mode);
    wrap1_d = wrap_q;
    ena1_d  = ena;
  end

  // Waveform generation from the stage-1 phase.
  always_comb begin
    quad    = p1_q[PHASE_W-1 -: 2];
    if (quad[0]) begin
      lut_idx = ~p1_q[PHASE_W-3:0];
    end else begin
      lut_idx = p1_q[PHASE_W-3:0];
    end
    tri_val = p1_q[PHASE_W-2:0] ^ {(PHASE_W-1){p1_q[PHASE_W-1]}};
    case (mode1_q)
      MODE_SINE: begin
        if (!quad[1]) begin
          wave_d = MID + OUT_W'(lut_mag);
        end else begin
          wave_d = MID - OUT_W'(lut_mag);
        end
      end
      MODE_TRI: wave_d = OUT_W'({tri_val, {OUT_W{1'b0}}} >> (PHASE_W - 1));
      MODE_SAW: wave_d = OUT_W'({p1_q, {OUT_W{1'b0}}} >> PHASE_W);
      MODE_SQR: begin
        if (p1_q[PHASE_W-1]) begin
          wave_d = {OUT_W{1'b0}};
        end else begin
          wave_d = {OUT_W{1'b1}};
        end
      end
      default: wave_d = {OUT_W{1'b0}};
    endcase
    sync_d  = wrap1_q;
    valid_d = ena1_q;
  end

  dds_quarter_sine_lut #(
    .PHASE_W(PHASE_W),
    .OUT_W  (OUT_W)
  ) u_lut (
    .idx(lut_idx),
    .mag(lut_mag)
  );

  // Accumulator, FTW, stage and load-FSM registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= {ACC_W{1'b0}};
      ftw_q   <= {ACC_W{1'b0}};
      stage_q <= {ACC_W{1'b0}};
      wrap_q  <= 1'b0;
      st_q    <= ST_IDLE;
      pend_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ftw_q   <= ftw_d;
      stage_q <= stage_d;
      wrap_q  <= wrap_d;
      st_q    <= st_d;
      pend_q  <= pend_d;
    end
  end

  // Output pipeline registers; they flow regardless of ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_q    <= {PHASE_W{1'b0}};
      mode1_q <= MODE_SINE;
      wrap1_q <= 1'b0;
      ena1_q  <= 1'b0;
      wave_q  <= {OUT_W{1'b0}};
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      p1_q    <= p1_d;
      mode1_q <= mode1_d;
      wrap1_q <= wrap1_d;
      ena1_q  <= ena1_d;
      wave_q  <= wave_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  assign wave_out    = wave_q;
  assign wave_valid  = valid_q;
  assign sync_out    = sync_q;
  assign ftw_pending = pend_q;

endmodule

// File: tb/tb_dds_nco_core.sv
// tb_dds_nco_core: directed and randomized bench for dds_nco_core with an
// arithmetic reference model (default parameters 16/14/12).
module tb_dds_nco_core;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n, ena, ftw_valid, ftw_last;
  logic [7:0]  ftw_byte;
  logic [1:0]  mode;
  logic [13:0] phase_off;
  logic [11:0] wave_out;
  logic        wave_valid, sync_out, ftw_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_nco_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ftw_valid  (ftw_valid),
    .ftw_byte   (ftw_byte),
    .ftw_last   (ftw_last),
    .mode       (mode),
    .phase_off  (phase_off),
    .wave_out   (wave_out),
    .wave_valid (wave_valid),
    .sync_out   (sync_out),
    .ftw_pending(ftw_pending)
  );

  // ---------------- reference model ----------------
  int m_acc, m_ftw, m_stage, m_lfsr;
  bit m_pend, m_wrapped;
  int r_p, r_mode;
  bit r_wrap, r_ena;
  int e_wave;
  bit e_valid, e_sync, e_pend;
  bit cmp_en = 1'b0;
  int t_sum, t_nftw, t_fb;
  bit t_carry;

  function automatic int wave_of(input int p, input int md);
    int q, i, ii, mag, t;
    case (md)
      0: begin
        q   = p / 4096;
        i   = p % 4096;
        ii  = (q % 2 == 1) ? 4095 - i : i;
        mag = $rtoi(2047.0 * $sin(PI / 2.0 * ii / 4096.0) + 0.5);
        return (q < 2) ? 2048 + mag : 2048 - mag;
      end
      1: begin
        t = (p >= 8192) ? 16383 - p : p;
        return t / 2;
      end
      2: return p / 4;
      default: return (p < 8192) ? 4095 : 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_acc = 0; m_ftw = 0; m_stage = 0; m_pend = 0; m_wrapped = 0; m_lfsr = 1;
      r_p = 0; r_mode = 0; r_wrap = 0; r_ena = 0;
      e_wave = 0; e_valid = 0; e_sync = 0; e_pend = 0;
    end else begin
      e_wave  = wave_of(r_p, r_mode);
      e_sync  = r_wrap;
      e_valid = r_ena;
`ifdef DDS_PHASE_DITHER_EN
      r_p = (((m_acc + (m_lfsr % 4)) / 4) + int'(phase_off)) % 16384;
`else
      r_p = ((m_acc / 4) + int'(phase_off)) % 16384;
`endif
      r_mode  = int'(mode);
      r_wrap  = m_wrapped;
      r_ena   = ena;
      t_sum   = m_acc + m_ftw;
      t_carry = ena && (t_sum >= 65536);
      t_nftw  = m_ftw;
      if (ftw_valid) begin
        m_stage = ((m_stage * 256) + int'(ftw_byte)) % 65536;
        m_pend  = ftw_last;
      end else if (m_pend && (!ena || t_carry)) begin
        t_nftw = m_stage;
        m_pend = 0;
      end
      if (ena) begin
        m_acc = t_sum % 65536;
        t_fb   = ((m_lfsr / 16384) ^ (m_lfsr / 8192)) % 2;
        m_lfsr = ((m_lfsr * 2) + t_fb) % 32768;
      end
      m_wrapped = t_carry;
      m_ftw     = t_nftw;
      e_pend    = m_pend;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks += 4;
      if (int'(wave_out) != e_wave) begin
        errors++;
        $display("FAIL wave_out @%0t: got 0x%0h want 0x%0h", $time, wave_out, e_wave);
      end
      if (wave_valid != e_valid) begin
        errors++;
        $display("FAIL wave_valid @%0t: got %0d want %0d", $time, wave_valid, e_valid);
      end
      if (sync_out != e_sync) begin
        errors++;
        $display("FAIL sync_out @%0t: got %0d want %0d", $time, sync_out, e_sync);
      end
      if (ftw_pending != e_pend) begin
        errors++;
        $display("FAIL ftw_pending @%0t: got %0d want %0d", $time, ftw_pending, e_pend);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ftw_valid = 1'b1;
    ftw_byte  = b;
    ftw_last  = last;
    tick();
    ftw_valid = 1'b0;
    ftw_last  = 1'b0;
  endtask

  task automatic wait_sync(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sync_out && n < bound);
    chk("sync_seen", int'(sync_out), 1);
  endtask

  // ---------------- stimulus ----------------
  int n, prev, w0, cnt;

  initial begin
    rst_n = 1'b0; ena = 1'b1; ftw_valid = 1'b0; ftw_last = 1'b0;
    ftw_byte = 8'h00; mode = 2'd0; phase_off = 14'h0000;

    // Reset
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    chk("rst_wave", int'(wave_out), 0);
    chk("rst_valid", int'(wave_valid), 0);
    chk("rst_sync", int'(sync_out), 0);
    chk("rst_pend", int'(ftw_pending), 0);
    rst_n = 1'b1;
    tick();
    chk("valid_1clk", int'(wave_valid), 0);
    tick();
    chk("valid_2clk", int'(wave_valid), 1);

    // Sine at fixed phase 0 with varying offset
    mode = 2'd0;
    phase_off = 14'h0000; tick(); tick(); tick(); chk("sine_0000", int'(wave_out), 'h800);
    phase_off = 14'h1000; tick(); tick(); tick(); chk("sine_1000", int'(wave_out), 'hFFF);
    phase_off = 14'h2000; tick(); tick(); tick(); chk("sine_2000", int'(wave_out), 'h800);
    phase_off = 14'h3000; tick(); tick(); tick(); chk("sine_3000", int'(wave_out), 'h001);
    phase_off = 14'h0000;

    // Saw and sync with FTW 0x0400
    ena = 1'b0; mode = 2'd2;
    send(8'h04, 1'b0);
    send(8'h00, 1'b1);
    tick();
    chk("pend_after_idle_commit", int'(ftw_pending), 0);
    ena = 1'b1;
    wait_sync(100, n);
    wait_sync(100, n);
    chk("sync_period", n, 64);
    chk("saw_at_sync", int'(wave_out), 0);
    for (int k = 0; k < 8; k++) begin
      prev = int'(wave_out);
      tick();
      chk("saw_step", (int'(wave_out) - prev) & 4095, 'h040);
    end

    // Square
    mode = 2'd3;
    tick(); tick(); tick();
    wait_sync(100, n);
    for (int k = 0; k < 64; k++) begin
      chk("square", int'(wave_out), (k < 32) ? 'hFFF : 0);
      tick();
    end

    // Commit at wrap: 0x0400 -> 0x0800
    mode = 2'd2;
    send(8'h08, 1'b0);
    send(8'h00, 1'b1);
    chk("pend_set", int'(ftw_pending), 1);
    wait_sync(100, n);
    chk("commit_sync_wave", int'(wave_out), 0);
    chk("commit_pend_clr", int'(ftw_pending), 0);
    tick();
    chk("commit_new_step", int'(wave_out), 'h080);

    // ftw_last coinciding with a wrap: commit deferred a full period
    send(8'h04, 1'b0);
    cnt = 0;
    while ((m_acc + m_ftw) < 65536 && cnt < 100) begin
      tick();
      cnt++;
    end
    send(8'h00, 1'b1);
    cnt = 0;
    while (ftw_pending && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("defer_len", cnt, 32);

    // Cancel a pending commit with a new byte
    send(8'h08, 1'b0);
    send(8'h00, 1'b1);
    chk("cancel_pend_set", int'(ftw_pending), 1);
    send(8'h10, 1'b0);
    chk("cancel_pend_clr", int'(ftw_pending), 0);
    repeat (70) tick();
    prev = int'(wave_out);
    tick();
    chk("cancel_old_step", (int'(wave_out) - prev) & 4095, 'h040);

    // ena=0 in PEND: immediate commit, accumulator holds
    ena = 1'b0;
    send(8'h00, 1'b1);
    chk("hold_pend_set", int'(ftw_pending), 1);
    tick();
    chk("hold_pend_clr", int'(ftw_pending), 0);
    w0 = int'(wave_out);
    tick(); tick();
    chk("hold_wave", int'(wave_out), w0);
    chk("hold_valid", int'(wave_valid), 0);
    ena = 1'b1;
    repeat (4) tick();
    prev = int'(wave_out);
    tick();
    chk("hold_new_step", (int'(wave_out) - prev) & 4095, 'h100);

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(199) != 0);
      ena       = ($urandom_range(7) != 0);
      ftw_valid = ($urandom_range(15) == 0);
      ftw_byte  = 8'($urandom);
      ftw_last  = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) mode = 2'($urandom);
      if ($urandom_range(7) == 0) phase_off = 14'($urandom);
      tick();
    end
    rst_n = 1'b1; ftw_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
